// File: rtl/add_accumulator_pkg.sv
// Shared definitions for the add accumulator: default widths and FSM state encoding.
package add_accumulator_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int COUNT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/add_flags_stage.sv
// Combinational WIDTH-bit adder returning sum, carry-out of the MSB and signed overflow.
// Zero latency; no flow control of its own.
module add_flags_stage #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o    = full_sum[WIDTH-1:0];
    assign carry_o  = full_sum[WIDTH];
    // Signed overflow: like-signed operands producing a result of the other sign.
    assign ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/add_accumulator.sv
// Sums a burst of len operands from a valid/ready stream into one result with sticky flags.
// Result valid the cycle after the last operand handshake; held until out_ready.
module add_accumulator
    import add_accumulator_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   acc,
    output logic               carry,
    output logic               overflow,
    output logic               zero,
    output logic               sign,
    output logic               parity,
    output logic               busy
);

    state_e             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic               carry_q;
    logic               ovf_q;
    logic [COUNT_W-1:0] count_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [WIDTH-1:0]   acc_d;
    logic               co;
    logic               ov;

    add_flags_stage #(
        .WIDTH (WIDTH)
    ) u_add (
        .a_i     (acc_q),
        .b_i     (in_data),
        .sum_o   (acc_d),
        .carry_o (co),
        .ovf_o   (ov)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (len != '0) begin
                            count_q    <= len;
                            state_q    <= S_ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc_q   <= acc_d;
                        carry_q <= carry_q | co;
                        ovf_q   <= ovf_q | ov;
                        count_q <= count_q - COUNT_W'(1);
                        if (count_q == COUNT_W'(1)) begin
                            state_q     <= S_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // start is deliberately ignored here, even alongside out_ready.
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign acc       = acc_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = (acc_q == '0);
    assign sign      = acc_q[WIDTH-1];
    assign parity    = ~^acc_q;

endmodule

// File: tb/tb_add_accumulator.sv
// Bench for add_accumulator: directed bursts with literal results plus randomized bursts,
// all outputs compared every cycle against an integer-arithmetic model of the accumulator.
module tb_add_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] acc;
    logic        carry, overflow, zero, sign, parity, busy;

    int errors = 0;
    int checks = 0;

    add_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign),
        .parity    (parity),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle, 1=accumulating, 2=result pending.
    int          m_phase;
    logic [15:0] m_acc;
    logic        m_c, m_v;
    int          m_left;

    function automatic logic [16:0] add17(input logic [15:0] a, input logic [15:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic sovf(input logic [15:0] a, input logic [15:0] b);
        int r;
        r = int'($signed(a)) + int'($signed(b));
        return (r > 32767) || (r < -32768);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_acc <= '0; m_c <= 1'b0; m_v <= 1'b0; m_left <= 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_acc <= '0; m_c <= 1'b0; m_v <= 1'b0;
                m_left  <= int'(len);
                m_phase <= (len == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_acc  <= add17(m_acc, in_data) & 17'hFFFF;
                m_c    <= m_c | add17(m_acc, in_data) > 17'hFFFF;
                m_v    <= m_v | sovf(m_acc, in_data);
                m_left <= m_left - 1;
                if (m_left == 1) m_phase <= 2;
            end
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("in_ready",  int'(in_ready),  int'(m_phase == 1));
        chk("out_valid", int'(out_valid), int'(m_phase == 2));
        chk("busy",      int'(busy),      int'(m_phase != 0));
        chk("acc",       int'(acc),       int'(m_acc));
        chk("carry",     int'(carry),     int'(m_c));
        chk("overflow",  int'(overflow),  int'(m_v));
        chk("zero",      int'(zero),      int'(m_acc == 0));
        chk("sign",      int'(sign),      int'(m_acc >= 16'h8000));
        chk("parity",    int'(parity),    int'($countones(m_acc) % 2 == 0));
    end

    logic [15:0] opq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one burst from opq; gap cycles before operand gap_at, hold cycles of backpressure on the result.
    task automatic burst(input int n, input int gap_at, input int gap_len, input int hold, input bit rnd_gaps);
        int t;
        start = 1'b1; len = 8'(n);
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at || (rnd_gaps && $urandom_range(3) == 0)) begin
                in_valid = 1'b0;
                repeat (i == gap_at ? gap_len : 1) begin
                    if ($urandom_range(1) == 1) start = 1'b1;
                    step();
                    start = 1'b0;
                end
            end
            in_valid = 1'b1; in_data = opq[i];
            t = 0;
            while (!in_ready && t < 50) begin step(); t++; end
            if (t >= 50) chk("in_ready_timeout", 0, 1);
            step();
        end
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 50) begin step(); t++; end
        if (t >= 50) chk("out_valid_timeout", 0, 1);
        repeat (hold) begin
            start = ($urandom_range(1) == 1);
            step();
        end
        out_ready = 1'b1; start = 1'b1;
        step();
        out_ready = 1'b0; start = 1'b0;
    endtask

    task automatic chk_res(input string name, input int a, input int c, input int v, input int z, input int s, input int p);
        chk({name, ".acc"}, int'(acc), a);
        chk({name, ".carry"}, int'(carry), c);
        chk({name, ".ovf"}, int'(overflow), v);
        chk({name, ".zero"}, int'(zero), z);
        chk({name, ".sign"}, int'(sign), s);
        chk({name, ".parity"}, int'(parity), p);
    endtask

    initial begin
        int n;
        #2;
        chk("rst.acc", int'(acc), 0);
        chk("rst.zero", int'(zero), 1);
        chk("rst.parity", int'(parity), 1);
        chk("rst.busy", int'(busy), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        opq = '{16'h0001, 16'h0002, 16'h0003};
        burst(3, -1, 0, 0, 0);
        chk_res("t1", 16'h0006, 0, 0, 0, 0, 1);

        opq = '{16'hFFFE, 16'h0002};
        burst(2, -1, 0, 0, 0);
        chk_res("t2", 16'h0000, 1, 0, 1, 0, 1);

        opq = '{16'h7FFF, 16'h0001};
        burst(2, -1, 0, 0, 0);
        chk_res("t3", 16'h8000, 0, 1, 0, 1, 0);

        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        chk("t4.out_valid", int'(out_valid), 1);
        chk_res("t4", 16'h0000, 0, 0, 1, 0, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4.idle_valid", int'(out_valid), 0);

        opq = '{16'h0010, 16'h0020, 16'h0030};
        burst(3, 1, 4, 5, 0);
        chk_res("t5", 16'h0060, 0, 0, 0, 0, 1);

        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6.rst_acc", int'(acc), 0);
        chk("t6.rst_busy", int'(busy), 0);
        chk("t6.rst_in_ready", int'(in_ready), 0);
        step();
        rst_n = 1'b1;
        step();
        opq = '{16'h0005};
        burst(1, -1, 0, 0, 0);
        chk_res("t6", 16'h0005, 0, 0, 0, 0, 1);

        for (int b = 0; b < 40; b++) begin
            n = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 6));
            opq.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(3))
                    0: opq.push_back(16'h7FFF);
                    1: opq.push_back(16'h8000);
                    default: opq.push_back(16'($urandom));
                endcase
            end
            burst(n, -1, 0, int'($urandom_range(3)), 1);
            repeat ($urandom_range(2)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
